// File: rtl/ram_obi_bridge_pkg.sv
// Shared types and helpers for the OBI-to-prim_ram_2p port-A bridge.
// The optional feature is selected with RAM_OBI_BRIDGE_RANGE_CHECK_EN in ram_2p_obi_bridge.sv.
package ram_obi_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } bridge_state_e;

    // Widest byte-enable vector the helper accepts; callers truncate to their Width.
    localparam int unsigned MaxBytes = 64;

    function automatic logic [8*MaxBytes-1:0] be2bitmask(input logic [MaxBytes-1:0] be);
        logic [8*MaxBytes-1:0] mask;
        mask = '0;
        for (int i = 0; i < MaxBytes; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_2p_obi_bridge.sv
// Core-side OBI req/gnt/rvalid to prim_ram_2p port-A valid/ready bridge, one outstanding access.
// Define RAM_OBI_BRIDGE_RANGE_CHECK_EN to answer out-of-range addresses with err_o instead of wrapping.
module ram_2p_obi_bridge
    import ram_obi_bridge_pkg::*;
#(
    parameter int unsigned Width     = 32,
    parameter int unsigned Depth     = 128,
    parameter int unsigned AddrWidth = 32,
    localparam int unsigned Aw = $clog2(Depth),
    localparam int unsigned Bo = $clog2(Width / 8)
) (
    input  logic                 clk_a_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [Width/8-1:0]   be_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [Width-1:0]     wdata_i,
    output logic                 rvalid_o,
    output logic [Width-1:0]     rdata_o,
    output logic                 err_o,
    output logic                 a_arvalid_o,
    output logic                 a_awvalid_o,
    output logic                 a_wvalid_o,
    output logic                 a_write_o,
    output logic [Aw-1:0]        a_araddr_o,
    output logic [Aw-1:0]        a_awaddr_o,
    output logic [Width-1:0]     a_wdata_o,
    output logic [Width-1:0]     a_wmask_o,
    input  logic                 a_arready_i,
    input  logic                 a_awready_i,
    input  logic                 a_wready_i,
    input  logic                 a_rvalid_i,
    input  logic [Width-1:0]     a_rdata_i,
    output logic                 a_rready_o,
    input  logic                 a_bvalid_i,
    output logic                 a_bready_o
);

    bridge_state_e    state_q, state_d;
    logic             we_q, we_d;
    logic [Aw-1:0]    addr_q, addr_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [Width-1:0] mask_q, mask_d;
    logic [Width-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [Width-1:0] be_mask;
    logic             out_of_range;

    for (genvar i = 0; i < Width / 8; i++) begin : g_mask
        assign be_mask[8*i +: 8] = {8{be_i[i]}};
    end

`ifdef RAM_OBI_BRIDGE_RANGE_CHECK_EN
    localparam int unsigned UpW = AddrWidth - Bo;

    logic unused_addr;
    assign unused_addr  = ^addr_i[Bo-1:0];
    assign out_of_range = {1'b0, addr_i[AddrWidth-1:Bo]} >= (UpW + 1)'(Depth);
    assign err_o        = err_q;
`else
    // Upper bits are dropped so the word address wraps modulo Depth.
    logic unused_addr;
    assign unused_addr  = ^{addr_i[AddrWidth-1:Bo+Aw], addr_i[Bo-1:0], err_q};
    assign out_of_range = 1'b0;
    assign err_o        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        gnt_o       = 1'b0;
        rvalid_o    = 1'b0;
        a_arvalid_o = 1'b0;
        a_awvalid_o = 1'b0;
        a_wvalid_o  = 1'b0;
        a_rready_o  = 1'b0;
        a_bready_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by reset so the core sees no grant while the bridge is held in reset.
                gnt_o = rst_ni;
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i[Bo +: Aw];
                    wdata_d = wdata_i;
                    mask_d  = we_i ? be_mask : '1;
                    err_d   = 1'b0;
                    state_d = StIssue;
                    if (out_of_range) begin
                        we_d    = 1'b0;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                if (we_q) begin
                    a_awvalid_o = 1'b1;
                    a_wvalid_o  = 1'b1;
                    if (a_awready_i && a_wready_i) begin
                        state_d = StWait;
                    end
                end else begin
                    a_arvalid_o = 1'b1;
                    if (a_arready_i) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (we_q) begin
                    a_bready_o = 1'b1;
                    if (a_bvalid_i) begin
                        state_d = StResp;
                    end
                end else begin
                    a_rready_o = 1'b1;
                    if (a_rvalid_i) begin
                        rdata_d = a_rdata_i;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                rvalid_o = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_a_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Write qualifier is held from ISSUE through RESP alongside address, data and mask.
    assign a_write_o  = we_q & (state_q != StIdle);
    assign a_araddr_o = addr_q;
    assign a_awaddr_o = addr_q;
    assign a_wdata_o  = wdata_q;
    assign a_wmask_o  = mask_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_ram_2p_obi_bridge.sv
// Self-checking bench for ram_2p_obi_bridge with a behavioural port-A RAM model.
module tb_ram_2p_obi_bridge;

    localparam int unsigned Width     = 32;
    localparam int unsigned Depth     = 128;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned Aw        = 7;

    logic                 clk;
    logic                 rst_ni;
    logic                 req;
    logic                 gnt_o;
    logic                 we;
    logic [3:0]           be;
    logic [AddrWidth-1:0] addr;
    logic [Width-1:0]     wdata;
    logic                 rvalid_o;
    logic [Width-1:0]     rdata_o;
    logic                 err_o;
    logic                 a_arvalid_o, a_awvalid_o, a_wvalid_o, a_write_o;
    logic [Aw-1:0]        a_araddr_o, a_awaddr_o;
    logic [Width-1:0]     a_wdata_o, a_wmask_o;
    logic                 ar_rdy, aw_rdy, w_rdy;
    logic                 ram_rvalid, ram_bvalid;
    logic [Width-1:0]     ram_rdata;
    logic                 a_rready_o, a_bready_o;
    logic [Width-1:0]     mem [Depth];

    int checks = 0;
    int errors = 0;
    int ram_act = 0;
    int rv_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_2p_obi_bridge #(
        .Width    (Width),
        .Depth    (Depth),
        .AddrWidth(AddrWidth)
    ) dut (
        .clk_a_i    (clk),
        .rst_ni     (rst_ni),
        .req_i      (req),
        .gnt_o      (gnt_o),
        .we_i       (we),
        .be_i       (be),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .a_arvalid_o(a_arvalid_o),
        .a_awvalid_o(a_awvalid_o),
        .a_wvalid_o (a_wvalid_o),
        .a_write_o  (a_write_o),
        .a_araddr_o (a_araddr_o),
        .a_awaddr_o (a_awaddr_o),
        .a_wdata_o  (a_wdata_o),
        .a_wmask_o  (a_wmask_o),
        .a_arready_i(ar_rdy),
        .a_awready_i(aw_rdy),
        .a_wready_i (w_rdy),
        .a_rvalid_i (ram_rvalid),
        .a_rdata_i  (ram_rdata),
        .a_rready_o (a_rready_o),
        .a_bvalid_i (ram_bvalid),
        .a_bready_o (a_bready_o)
    );

    // Port-A RAM model: one-cycle read data / write response after the request handshake.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            ram_rvalid <= 1'b0;
            ram_bvalid <= 1'b0;
            ram_rdata  <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            if (a_arvalid_o && ar_rdy) begin
                ram_rvalid <= 1'b1;
                ram_rdata  <= mem[a_araddr_o];
            end else if (a_rready_o) begin
                ram_rvalid <= 1'b0;
            end
            if (a_awvalid_o && a_wvalid_o && a_write_o && aw_rdy && w_rdy) begin
                mem[a_awaddr_o] <= (mem[a_awaddr_o] & ~a_wmask_o) | (a_wdata_o & a_wmask_o);
                ram_bvalid      <= 1'b1;
            end else if (a_bready_o) begin
                ram_bvalid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (a_arvalid_o || a_awvalid_o) ram_act++;
        if (rvalid_o) rv_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mask;
        logic [31:0] exp_waddr;
    } vec_t;

    vec_t vecs[10];

    task automatic wait_rvalid(input string name);
        int n = 0;
        while (!rvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " rvalid seen"}, 32'(rvalid_o), 32'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        int   act0;
        v = vecs[idx];
        @(negedge clk);
        req   = 1'b1;
        we    = v.we;
        be    = v.be;
        addr  = v.addr;
        wdata = v.wdata;
        #1;
        check($sformatf("v%0d gnt", idx), 32'(gnt_o), 32'd1);
        act0 = ram_act;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!rvalid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d rdata", idx), rdata_o, v.exp_rdata);
        check($sformatf("v%0d err", idx), 32'(err_o), 32'(v.exp_err));
        check($sformatf("v%0d wmask", idx), a_wmask_o, v.exp_mask);
        check($sformatf("v%0d waddr", idx), 32'(a_araddr_o), v.exp_waddr);
        check($sformatf("v%0d gnt in resp", idx), 32'(gnt_o), 32'd0);
        check($sformatf("v%0d ram cycles", idx), 32'(ram_act - act0), v.exp_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        int gcyc[4];
        int rcyc[4];
        int grants;
        int rvs;
        int gnt_hi;
        int rv0;

        vecs[0] = '{1'b1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3, 32'hFFFFFFFF, 32'd4};
        vecs[1] = '{1'b0, 4'hF, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, 32'hFFFFFFFF, 32'd4};
        vecs[2] = '{1'b1, 4'hF, 32'h10,  32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 3, 32'hFFFFFFFF, 32'd4};
        vecs[3] = '{1'b1, 4'h1, 32'h10,  32'h000000AA, 32'hDEADBEEF, 1'b0, 3, 32'h000000FF, 32'd4};
        vecs[4] = '{1'b0, 4'hF, 32'h10,  32'h0,        32'hFFFFFFAA, 1'b0, 3, 32'hFFFFFFFF, 32'd4};
        vecs[5] = '{1'b1, 4'hC, 32'h1FC, 32'h12345678, 32'hFFFFFFAA, 1'b0, 3, 32'hFFFF0000, 32'd127};
        vecs[6] = '{1'b0, 4'hF, 32'h1FC, 32'h0,        32'h12340000, 1'b0, 3, 32'hFFFFFFFF, 32'd127};
        vecs[7] = '{1'b1, 4'hF, 32'h0,   32'hCAFEF00D, 32'h12340000, 1'b0, 3, 32'hFFFFFFFF, 32'd0};
        vecs[8] = '{1'b0, 4'hF, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0, 3, 32'hFFFFFFFF, 32'd0};
`ifdef RAM_OBI_BRIDGE_RANGE_CHECK_EN
        vecs[9] = '{1'b0, 4'hF, 32'h200, 32'h0,        32'h0,        1'b1, 1, 32'hFFFFFFFF, 32'd0};
`else
        vecs[9] = '{1'b0, 4'hF, 32'h200, 32'h0,        32'hCAFEF00D, 1'b0, 3, 32'hFFFFFFFF, 32'd0};
`endif

        rst_ni = 1'b0;
        req    = 1'b0;
        we     = 1'b0;
        be     = 4'h0;
        addr   = '0;
        wdata  = '0;
        ar_rdy = 1'b1;
        aw_rdy = 1'b1;
        w_rdy  = 1'b1;
        #1;
        check("reset gnt", 32'(gnt_o), 32'd0);
        check("reset ctrl", 32'({rvalid_o, err_o, a_arvalid_o, a_awvalid_o, a_wvalid_o,
                                 a_write_o, a_rready_o, a_bready_o}), 32'd0);
        check("reset rdata", rdata_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("gnt after reset", 32'(gnt_o), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Store with wready held low: both valids must stay up with stable address and data.
        @(negedge clk);
        w_rdy = 1'b0;
        req   = 1'b1;
        we    = 1'b1;
        be    = 4'hF;
        addr  = 32'h20;
        wdata = 32'h55667788;
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wstall%0d valids", k),
                  32'({a_awvalid_o, a_wvalid_o, a_write_o, a_arvalid_o}), 32'b1110);
            check($sformatf("wstall%0d awaddr", k), 32'(a_awaddr_o), 32'd8);
            check($sformatf("wstall%0d wdata", k), a_wdata_o, 32'h55667788);
            if (k == 0) @(negedge clk);
        end
        w_rdy = 1'b1;
        wait_rvalid("wstall");

        // Load with arready held low.
        @(negedge clk);
        ar_rdy = 1'b0;
        req    = 1'b1;
        we     = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rstall valids", 32'({a_arvalid_o, a_awvalid_o, a_write_o}), 32'b100);
        check("rstall araddr", 32'(a_araddr_o), 32'd8);
        ar_rdy = 1'b1;
        wait_rvalid("rstall");
        check("rstall rdata", rdata_o, 32'h55667788);

        // Back-to-back loads with req held high.
        @(negedge clk);
        req    = 1'b1;
        we     = 1'b0;
        addr   = 32'h10;
        grants = 0;
        rvs    = 0;
        gnt_hi = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (cyc < 12 && gnt_o) gnt_hi++;
            if (req && gnt_o && grants < 4) begin
                gcyc[grants] = cyc;
                grants++;
            end
            if (rvalid_o) begin
                if (rvs < 4) rcyc[rvs] = cyc;
                rvs++;
                check($sformatf("b2b rdata%0d", rvs), rdata_o, 32'hFFFFFFAA);
            end
            @(posedge clk);
            #1;
            if (grants == 3) req = 1'b0;
            @(negedge clk);
        end
        check("b2b grants", 32'(grants), 32'd3);
        check("b2b gnt cycles", 32'(gnt_hi), 32'd3);
        check("b2b rvalid count", 32'(rvs), 32'd3);
        if (grants == 3 && rvs == 3) begin
            check("b2b gnt1 cycle", 32'(gcyc[1]), 32'd4);
            check("b2b gnt2 cycle", 32'(gcyc[2]), 32'd8);
            check("b2b rv0 cycle", 32'(rcyc[0]), 32'd3);
            check("b2b rv1 cycle", 32'(rcyc[1]), 32'd7);
            check("b2b rv2 cycle", 32'(rcyc[2]), 32'd11);
        end

        // Reset while a load sits in WAIT.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h10;
        #1;
        check("rst-wait gnt", 32'(gnt_o), 32'd1);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst-wait in wait", 32'(a_rready_o), 32'd1);
        rv0    = rv_total;
        rst_ni = 1'b0;
        #1;
        check("rst-wait gnt low", 32'(gnt_o), 32'd0);
        check("rst-wait ctrl", 32'({rvalid_o, err_o, a_arvalid_o, a_awvalid_o, a_wvalid_o,
                                    a_write_o, a_rready_o, a_bready_o}), 32'd0);
        check("rst-wait rdata", rdata_o, 32'd0);
        check("rst-wait addr", 32'({a_araddr_o, a_awaddr_o}), 32'd0);
        check("rst-wait wdata", a_wdata_o, 32'd0);
        check("rst-wait wmask", a_wmask_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst-wait gnt after", 32'(gnt_o), 32'd1);
        repeat (4) @(negedge clk);
        check("rst-wait no rvalid", 32'(rv_total - rv0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
